// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the five-stage RV32I pipeline.
//   XLEN             : datapath width
//   NOP_INSTR        : canonical bubble instruction (addi x0,x0,0)
//   RESET_PC_DEFAULT : default program counter after reset
//   if_id_t          : contents of the IF/ID pipeline register
//   IF_ID_BUBBLE     : IF/ID value after a flush or reset
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        pc:       32'h0000_0000,
        pc_plus4: 32'h0000_0000,
        instr:    NOP_INSTR,
        valid:    1'b0
    };

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// Generic pipeline register with hold (enable low), flush and async reset.
// Flush has priority over enable, so a flush can kill a stalled entry.
// Reused for later pipeline registers by changing WIDTH / BUBBLE.
//   clk    in  : rising-edge clock
//   rst    in  : asynchronous active-high reset, loads BUBBLE
//   enable in  : capture d when high, otherwise hold
//   flush  in  : load BUBBLE at the next edge
//   d      in  : next register contents
//   q      out : current register contents
// ---------------------------------------------------------------------------
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int               WIDTH  = $bits(if_id_t),
    parameter logic [WIDTH-1:0] BUBBLE = IF_ID_BUBBLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (flush) begin
            q <= BUBBLE;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and registers the fetched word into IF/ID.
// Edge priority: redirect > stall > advance.
//   clk            in  : rising-edge clock
//   rst            in  : asynchronous active-high reset
//   imem_addr      out : byte address to instruction memory (= PC)
//   imem_rdata     in  : instruction word returned in the same cycle
//   stall          in  : load-use stall, hold PC and IF/ID
//   redirect_valid in  : taken branch / JAL resolved in EX
//   redirect_pc    in  : redirect target, bits [1:0] ignored
//   if_id_pc       out : PC of the instruction in IF/ID
//   if_id_pc_plus4 out : if_id_pc + 4
//   if_id_instr    out : instruction in IF/ID
//   if_id_valid    out : IF/ID holds a real instruction
//   fetch_count    out : number of valid instructions written into IF/ID
// ---------------------------------------------------------------------------
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        advance;
    if_id_t      if_id_d;
    if_id_t      if_id_q;

    // The target's low bits are dropped so PC stays word aligned.
    logic        unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];

    assign pc_plus4 = pc + 32'd4;
    assign advance  = !redirect_valid && !stall;

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = {redirect_pc[31:2], 2'b00};
        end else if (!stall) begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Only an advance writes a real instruction, so only it is counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 32'd0;
        end else if (advance) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    always_comb begin
        if_id_d          = IF_ID_BUBBLE;
        if_id_d.pc       = pc;
        if_id_d.pc_plus4 = pc_plus4;
        if_id_d.instr    = imem_rdata;
        if_id_d.valid    = 1'b1;
    end

    if_id_reg #(
        .WIDTH  ($bits(if_id_t)),
        .BUBBLE (IF_ID_BUBBLE)
    ) u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .enable (!stall),
        .flush  (redirect_valid),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    assign imem_addr      = pc;
    assign if_id_pc       = if_id_q.pc;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_instr    = if_id_q.instr;
    assign if_id_valid    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Drives directed and random stall/redirect patterns into fetch_stage.
// The driver predicts the visible state after each edge and queues it;
// a monitor pops one prediction per edge and compares it to the outputs.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] count;
    } expect_t;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int tests_run;
    int tests_failed;

    expect_t sb_queue[$];

    // Reference model state: program counter, IF/ID contents, counter.
    logic [31:0] m_pc;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_pc4;
    logic [31:0] m_if_instr;
    logic        m_if_valid;
    logic [31:0] m_count;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: known words at low addresses, a zero word at 0x40,
    // an address-derived pattern everywhere else.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h00: memWord = 32'h0050_0093;
            32'h04: memWord = 32'h00a0_0113;
            32'h08: memWord = 32'h0020_81b3;
            32'h0C: memWord = 32'h0031_8233;
            32'h10: memWord = 32'h0040_2023;
            32'h14: memWord = 32'h0001_2283;
            32'h18: memWord = 32'h0052_8333;
            32'h1C: memWord = 32'h0063_03b3;
            32'h20: memWord = 32'h0073_8463;
            32'h24: memWord = 32'h02a0_0393;
            32'h40: memWord = 32'h0000_0000;
            default: memWord = a ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    assign imem_rdata = memWord(imem_addr);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %08h, expected %08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_pc       = 32'h0;
        m_if_pc    = 32'h0;
        m_if_pc4   = 32'h0;
        m_if_instr = 32'h0000_0013;
        m_if_valid = 1'b0;
        m_count    = 32'h0;
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic applyStimulus(input logic s, input logic rv,
                                 input logic [31:0] rpc);
        expect_t e;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rv) begin
            m_pc       = rpc & 32'hFFFF_FFFC;
            m_if_pc    = 32'h0;
            m_if_pc4   = 32'h0;
            m_if_instr = 32'h0000_0013;
            m_if_valid = 1'b0;
        end else if (!s) begin
            m_if_pc    = m_pc;
            m_if_pc4   = m_pc + 32'd4;
            m_if_instr = memWord(m_pc);
            m_if_valid = 1'b1;
            m_count    = m_count + 32'd1;
            m_pc       = m_pc + 32'd4;
        end
        e.addr  = m_pc;
        e.pc    = m_if_pc;
        e.pc4   = m_if_pc4;
        e.instr = m_if_instr;
        e.valid = m_if_valid;
        e.count = m_count;
        sb_queue.push_back(e);
        @(posedge clk);
        @(negedge clk);
        stall          = 1'b0;
        redirect_valid = 1'b0;
    endtask

    // Monitor: one prediction is consumed per active edge outside reset.
    always @(posedge clk) begin
        expect_t e;
        #1;
        if (!rst && sb_queue.size() > 0) begin
            e = sb_queue.pop_front();
            checkOutput("imem_addr", imem_addr, e.addr);
            checkOutput("if_id_pc", if_id_pc, e.pc);
            checkOutput("if_id_pc_plus4", if_id_pc_plus4, e.pc4);
            checkOutput("if_id_instr", if_id_instr, e.instr);
            checkOutput("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
            checkOutput("fetch_count", fetch_count, e.count);
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_imem_addr"}, imem_addr, 32'h0);
        checkOutput({tag, "_if_id_pc"}, if_id_pc, 32'h0);
        checkOutput({tag, "_if_id_pc_plus4"}, if_id_pc_plus4, 32'h0);
        checkOutput({tag, "_if_id_instr"}, if_id_instr, 32'h0000_0013);
        checkOutput({tag, "_if_id_valid"}, {31'b0, if_id_valid}, 32'h0);
        checkOutput({tag, "_fetch_count"}, fetch_count, 32'h0);
    endtask

    task automatic randomRun(input int cycles);
        logic        s;
        logic        rv;
        logic [31:0] rpc;
        for (int i = 0; i < cycles; i++) begin
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 6) == 0);
            case ($urandom_range(0, 2))
                0:       rpc = $urandom_range(0, 63);
                1:       rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: rpc = $urandom;
            endcase
            applyStimulus(s, rv, rpc);
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        modelReset();

        // Power-on reset.
        rst = 1'b1;
        #1;
        checkResetState("por");
        @(negedge clk);
        rst = 1'b0;

        // Straight-line fetch from 0x00.
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("first_instr", if_id_instr, 32'h0050_0093);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("second_pc", if_id_pc, 32'h0000_0004);
        checkOutput("second_instr", if_id_instr, 32'h00a0_0113);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("count_after_4", fetch_count, 32'd4);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Two stall cycles at PC 0x18.
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("stall_addr", imem_addr, 32'h0000_0018);
        checkOutput("stall_instr", if_id_instr, 32'h0001_2283);
        checkOutput("stall_count", fetch_count, 32'd6);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("release_pc", if_id_pc, 32'h0000_0018);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Redirect to 0x24 while PC = 0x20.
        applyStimulus(1'b0, 1'b1, 32'h0000_0024);
        checkOutput("redir_addr", imem_addr, 32'h0000_0024);
        checkOutput("redir_instr", if_id_instr, 32'h0000_0013);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("redir_target_instr", if_id_instr, 32'h02a0_0393);

        // Redirect together with stall, misaligned target.
        applyStimulus(1'b1, 1'b1, 32'h0000_0031);
        checkOutput("redir_stall_addr", imem_addr, 32'h0000_0030);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // PC wrap at the top of the address space.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("wrap_addr", imem_addr, 32'h0000_0000);
        checkOutput("wrap_pc_plus4", if_id_pc_plus4, 32'h0000_0000);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Back-to-back redirects, then fetch the zero word at 0x40.
        applyStimulus(1'b0, 1'b1, 32'h0000_0100);
        applyStimulus(1'b0, 1'b1, 32'h0000_0040);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("zero_word_valid", {31'b0, if_id_valid}, 32'h1);

        randomRun(300);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        checkResetState("async");
        modelReset();
        @(negedge clk);
        rst = 1'b0;

        randomRun(200);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
